// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants for the switch input conditioning stage
// Contents:
//   SW_WIDTH            board slide-switch count
//   DEBOUNCE_CYCLES_DEF default debounce window (10 ms at 100 MHz)
//   cnt_width()         smallest counter width W with 2^W > cycles
package gpio_pkg;

    localparam int unsigned SW_WIDTH            = 16;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/gpio_in_debounce_if.sv
// rtl/gpio_in_debounce_if.sv - signal bundle between switch conditioner and its consumer
// Signals:
//   raw_i       unsynchronised switch levels        (master -> slave)
//   irq_mask_i  per-bit interrupt enable            (master -> slave)
//   irq_clr_i   sticky interrupt clear              (master -> slave)
//   stable_o    debounced level                     (slave -> master)
//   rise_o      one-cycle accepted 0->1 pulses      (slave -> master)
//   fall_o      one-cycle accepted 1->0 pulses      (slave -> master)
//   change_o    OR of all rise/fall pulses          (slave -> master)
//   irq_o       sticky interrupt request            (slave -> master)
interface gpio_in_debounce_if #(
    parameter int unsigned WIDTH = 16
);

    logic [WIDTH-1:0] raw_i;
    logic [WIDTH-1:0] irq_mask_i;
    logic             irq_clr_i;
    logic [WIDTH-1:0] stable_o;
    logic [WIDTH-1:0] rise_o;
    logic [WIDTH-1:0] fall_o;
    logic             change_o;
    logic             irq_o;

    modport master (
        output raw_i, irq_mask_i, irq_clr_i,
        input  stable_o, rise_o, fall_o, change_o, irq_o
    );

    modport slave (
        input  raw_i, irq_mask_i, irq_clr_i,
        output stable_o, rise_o, fall_o, change_o, irq_o
    );

endinterface

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser plus counting debouncer for one input bit
// Ports:
//   clk_i     system clock
//   arstn_i   asynchronous active-low reset
//   raw_i     asynchronous input level
//   stable_o  debounced level
//   rise_o    registered pulse when the stable level is accepted as 1
//   fall_o    registered pulse when the stable level is accepted as 0
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             st_q, st_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only advances while the synchronised level disagrees with
    // the accepted one, and is cleared on acceptance, so it tops out at
    // CNT_LAST and never wraps.
    always_comb begin
        st_d   = st_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != st_q) begin
            if (cnt_q == CNT_LAST) begin
                st_d   = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            st_q   <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= raw_i;
            s2_q   <= s1_q;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign stable_o = st_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// rtl/gpio_in_debounce.sv - per-bit debounced switch vector with change pulses and optional sticky irq
// Build option: GPIO_DEBOUNCE_IRQ_EN enables the sticky interrupt; otherwise irq_o is 0
//   and irq_mask_i / irq_clr_i are ignored.
// Ports:
//   clk_i    system clock
//   arstn_i  asynchronous active-low reset
//   bus      gpio_in_debounce_if slave: raw_i, irq_mask_i, irq_clr_i in;
//            stable_o, rise_o, fall_o, change_o, irq_o out
module gpio_in_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    gpio_in_debounce_if.slave  bus
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk_i    (clk_i),
            .arstn_i  (arstn_i),
            .raw_i    (bus.raw_i[i]),
            .stable_o (stable_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i])
        );
    end

    assign bus.stable_o = stable_w;
    assign bus.rise_o   = rise_w;
    assign bus.fall_o   = fall_w;
    assign bus.change_o = |(rise_w | fall_w);

`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic irq_q, irq_d;
    logic irq_set;

    assign irq_set = |((rise_w | fall_w) & bus.irq_mask_i);

    // A new event in the same cycle as a clear must not be lost.
    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (bus.irq_clr_i) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq_o = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{bus.irq_mask_i, bus.irq_clr_i};
    assign bus.irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb/tb_gpio_in_debounce.sv - scoreboard bench for gpio_in_debounce with DEBOUNCE_CYCLES=4
module tb_gpio_in_debounce;

    localparam int DC  = 4;
    localparam int LAT = 2 + DC;
`ifdef GPIO_DEBOUNCE_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] rise;
        logic [15:0] fall;
        logic [15:0] stable;
    } exp_t;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   seen = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpio_in_debounce_if #(.WIDTH(16)) bus ();

    gpio_in_debounce #(
        .WIDTH           (16),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int c, input logic [15:0] v, input logic [15:0] r,
                             input logic [15:0] f);
        exp_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.stable = v;
        q.push_back(e);
        pushed++;
    endtask

    task automatic drive(input logic [15:0] v, input logic [15:0] r, input logic [15:0] f);
        bus.raw_i = v;
        expect_at(cyc + LAT, v, r, f);
    endtask

    // Monitor: every change_o cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arstn) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: expected change at cycle %0d, none by %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (bus.change_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: rise 0x%0h fall 0x%0h at cycle %0d",
                             bus.rise_o, bus.fall_o, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    seen++;
                    chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rise", 64'(bus.rise_o), 64'(e.rise));
                    chk("fall", 64'(bus.fall_o), 64'(e.fall));
                    chk("stable", 64'(bus.stable_o), 64'(e.stable));
                end
            end else if ((bus.rise_o | bus.fall_o) != 16'h0) begin
                checks++;
                errors++;
                $display("FAIL pulse_without_change: rise 0x%0h fall 0x%0h at cycle %0d",
                         bus.rise_o, bus.fall_o, cyc);
            end
        end
    end

    initial begin
        bus.raw_i      = 16'h0000;
        bus.irq_mask_i = 16'h0000;
        bus.irq_clr_i  = 1'b0;
        tick(3);
        arstn = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("reset_idle", {bus.stable_o, bus.rise_o, bus.fall_o, bus.change_o, bus.irq_o}, 64'h0);
        end

        // single bit, latency boundary
        drive(16'h0001, 16'h0001, 16'h0000);
        tick(LAT - 1);
        chk("latency_minus_one", 64'(bus.stable_o), 64'h0000);
        tick(5);

        // 3-cycle glitch on bit 3 is filtered
        bus.raw_i = 16'h0009;
        tick(3);
        bus.raw_i = 16'h0001;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_filtered", 64'(bus.stable_o), 64'h0001);
        end

        // 4-cycle pulse on bit 3 is the shortest accepted
        drive(16'h0009, 16'h0008, 16'h0000);
        tick(4);
        drive(16'h0001, 16'h0000, 16'h0008);
        tick(10);

        // multi-bit simultaneous updates
        drive(16'h00F0, 16'h00F0, 16'h0001);
        tick(10);
        drive(16'h0F00, 16'h0F00, 16'h00F0);
        tick(10);
        drive(16'h0000, 16'h0000, 16'h0F00);
        tick(10);

        // sticky interrupt
        bus.irq_mask_i = 16'h0002;
        chk("irq_idle", 64'(bus.irq_o), 64'h0);
        drive(16'h0002, 16'h0002, 16'h0000);
        tick(LAT);
        chk("irq_before_pulse_seen", 64'(bus.irq_o), 64'h0);
        tick(1);
        chk("irq_set", 64'(bus.irq_o), 64'(IRQ_EN));
        tick(4);
        chk("irq_sticky", 64'(bus.irq_o), 64'(IRQ_EN));

        drive(16'h0003, 16'h0001, 16'h0000);
        tick(LAT - 1);
        bus.irq_clr_i = 1'b1;
        tick(1);
        bus.irq_clr_i = 1'b0;
        chk("irq_cleared", 64'(bus.irq_o), 64'h0);
        tick(1);
        chk("irq_masked_bit_ignored", 64'(bus.irq_o), 64'h0);

        drive(16'h0001, 16'h0000, 16'h0002);
        tick(LAT);
        bus.irq_clr_i = 1'b1;
        tick(1);
        bus.irq_clr_i = 1'b0;
        chk("irq_set_wins", 64'(bus.irq_o), 64'(IRQ_EN));
        tick(3);
        chk("irq_hold_after_tie", 64'(bus.irq_o), 64'(IRQ_EN));

        bus.irq_clr_i = 1'b1;
        tick(1);
        bus.irq_clr_i = 1'b0;
        chk("irq_clear_again", 64'(bus.irq_o), 64'h0);
        drive(16'h0000, 16'h0000, 16'h0001);
        tick(10);
        bus.irq_mask_i = 16'h0000;

        // reset while bit 5 is mid-count
        bus.raw_i = 16'h0020;
        tick(4);
        arstn = 1'b0;
        tick(1);
        chk("mid_count_reset",
            {bus.stable_o, bus.rise_o, bus.fall_o, bus.change_o, bus.irq_o}, 64'h0);
        tick(2);
        chk("held_in_reset", {bus.stable_o, bus.rise_o, bus.change_o}, 64'h0);
        arstn = 1'b1;
        expect_at(cyc + LAT, 16'h0020, 16'h0020, 16'h0000);
        tick(LAT - 1);
        chk("full_latency_after_reset", 64'(bus.stable_o), 64'h0000);
        tick(5);
        chk("accepted_after_reset", 64'(bus.stable_o), 64'h0020);
        tick(2);

        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL outstanding_pulse: expected at cycle %0d never seen", q[0].cyc);
            void'(q.pop_front());
        end
        chk("pulse_count", 64'(seen), 64'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-conditioning stage between the NEXYS4-DDR slide switches and the processor subsystem's `gpio_bi` input. It resynchronises 16 asynchronous switch lines into the `clk_gen` domain and debounces each bit independently. It presents a glitch-free stable vector plus one-cycle rise, fall and change pulses, so software polling GPIO never sees metastable or bouncing values.

## Interface
- `WIDTH`, 16: number of input bits.
- `DEBOUNCE_CYCLES`, 1000000: consecutive mismatching cycles required to accept a new level (10 ms at 100 MHz); legal range ≥2.
- `CNT_W`, 20: counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk_i`  in  1  system clock (`clk_gen`).
- `arstn_i`  in  1  asynchronous active-low reset.
- `raw_i`  in  WIDTH  unsynchronised switch inputs.
- `stable_o`  out  WIDTH  debounced level; feeds `gpio_bi` switch field.
- `rise_o`  out  WIDTH  one-cycle pulse per bit on accepted 0→1.
- `fall_o`  out  WIDTH  one-cycle pulse per bit on accepted 1→0.
- `change_o`  out  1  OR of all `rise_o|fall_o`.
- `irq_mask_i`  in  WIDTH  per-bit interrupt enable.
- `irq_clr_i`  in  1  clears sticky interrupt.
- `irq_o`  out  1  sticky interrupt request.

## Operation
- Per bit: two-flop synchroniser `s1→s2`, counter `cnt`, stable register `st`.
- Each edge: if `s2 == st`, then `cnt <= 0`. Else if `cnt == DEBOUNCE_CYCLES-1`, then `st <= s2`, `cnt <= 0`, and a pulse fires. Else `cnt <= cnt+1`.
- A bounce back to `st` before the terminal count zeroes `cnt`; the next mismatch restarts from 0.
- Bits are fully independent; several bits may update on the same edge, and `change_o` is then a single-cycle 1.
- `rise_o[i]` = registered (`st` updating to 1); `fall_o[i]` = registered (`st` updating to 0); never both set on one bit.
- Counter never wraps: it saturates by construction at `DEBOUNCE_CYCLES-1`.
- Reset values: `s1`, `s2`, `st`, `cnt` = 0; `stable_o`, `rise_o`, `fall_o` = 0; `change_o` = 0; `irq_o` = 0.
- A switch already high at reset release is accepted after the normal latency and produces a `rise_o` pulse. This is intended.
- Reset asserted mid-count discards the count; no pulse is emitted.

## Timing
- Latency: a raw edge held steady appears on `stable_o` on edge 2+DEBOUNCE_CYCLES after the first edge that samples it into `s1`.
- Pulses assert on the same edge `stable_o` updates and deassert on the next edge.
- Minimum accepted pulse width on `raw_i`: DEBOUNCE_CYCLES clocks; shorter pulses are filtered entirely.
- `irq_o` updates one edge after the qualifying pulse or after `irq_clr_i`.

## Configuration
- `GPIO_DEBOUNCE_IRQ_EN` defined: `irq_o` sets when any bit has `(rise_o|fall_o) & irq_mask_i` nonzero. It holds until `irq_clr_i`. On simultaneous set and clear, set wins.
- Not defined: irq logic is removed and `irq_o` is tied 0. `irq_mask_i` and `irq_clr_i` remain as ports and are ignored.

## Structure
- Shared package `gpio_pkg`: default `DEBOUNCE_CYCLES`, `CNT_W` derivation constant, and the board switch width of 16.
- Sub-module `debounce_bit` holds the synchroniser, counter, stable flop and edge pulses for one bit. It is instantiated WIDTH times via generate.
- The top level contains only the instance array, the `change_o` reduction and the optional irq register.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, WIDTH=16.
- Reset with `raw_i`=0x0000, then release → all outputs 0 for 10 cycles.
- `raw_i`=0x0001 held → `stable_o`=0x0001 on edge 6 after change; `rise_o`=0x0001 and `change_o`=1 for exactly one cycle.
- Bit 3 toggles high for 3 cycles then low → `stable_o` stays 0x0000; no pulses.
- `raw_i` 0x00F0→0x0F00 in one cycle → one edge with `rise_o`=0x0F00, `fall_o`=0x00F0 and `change_o`=1 for one cycle.
- With `GPIO_DEBOUNCE_IRQ_EN`, `irq_mask_i`=0x0002 and bit 1 rising → `irq_o`=1 and sticky. Bit 0 change with `irq_clr_i` pulsed → `irq_o`=0. `irq_clr_i` on the same edge as a bit 1 pulse → `irq_o` stays 1.
- `arstn_i` asserted when `cnt`=2 on bit 5 → `stable_o`=0 and no pulse. After release with input held, acceptance takes the full 6 edges.
